// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory line responder.
package dmem_pkg;

  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned LAT_CNT_W   = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StAck  = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_line_array.sv
// Single-port synchronous line storage: registered read, write-first on a shared index.
module dmem_line_array #(
  parameter int unsigned DEPTH_LINES = 512,
  parameter int unsigned LINE_BITS   = 256,
  localparam int unsigned IdxW       = $clog2(DEPTH_LINES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdxW-1:0]      index,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  // Storage itself is not reset; only the read register is.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[index] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem_q[index];
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Data-memory line responder with fixed access latency and one-cycle ack.
// Optional DMEM_ADDR_CHECK_EN adds err_o for addresses beyond DEPTH_LINES.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH_LINES = 512,
  parameter int unsigned LINE_BITS   = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic                 err_o
`endif
);

  localparam int unsigned IdxW  = $clog2(DEPTH_LINES);
  localparam int unsigned IdxHi = IdxW + OFFSET_BITS - 1;

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q;
  logic                 wr_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic                 req_err;
  logic                 accept, ack_d, arr_we, arr_re;
  logic [LINE_BITS-1:0] arr_rdata;
  logic                 unused_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ack_d   = 1'b0;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          accept  = 1'b1;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? StAck : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_W'(1)) begin
          state_d = StAck;
        end
      end
      // The edge leaving StAck is the completion edge: ack rises, array is accessed.
      StAck: begin
        ack_d   = 1'b1;
        arr_we  = wr_q & ~req_err;
        arr_re  = ~wr_q & ~req_err;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_o   <= ack_d;
      if (accept) begin
        idx_q   <= addr_i[IdxHi:OFFSET_BITS];
        wr_q    <= write_i;
        wdata_q <= data_i;
      end
    end
  end

  dmem_line_array #(
    .DEPTH_LINES(DEPTH_LINES),
    .LINE_BITS  (LINE_BITS)
  ) u_array (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .index(idx_q),
    .wdata(wdata_q),
    .we   (arr_we),
    .re   (arr_re),
    .rdata(arr_rdata)
  );

`ifdef DMEM_ADDR_CHECK_EN
  logic err_q, rd_zero_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q     <= 1'b0;
      err_o     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= |addr_i[31:IdxHi+1];
      end
      err_o <= ack_d & err_q;
      // An erroring read blanks data_o until the next good read completes.
      if (ack_d && !wr_q) begin
        rd_zero_q <= err_q;
      end
    end
  end

  assign req_err     = err_q;
  assign data_o      = rd_zero_q ? '0 : arr_rdata;
  assign unused_addr = ^addr_i[OFFSET_BITS-1:0];
`else
  assign req_err     = 1'b0;
  assign data_o      = arr_rdata;
  assign unused_addr = ^{addr_i[31:IdxHi+1], addr_i[OFFSET_BITS-1:0]};
`endif

endmodule
